// File: rtl/if_inflight_cancel_tracker_pkg.sv
// Shared definitions for the IF in-flight cancel tracker.
// Flush source indices and count-width helper.
package if_inflight_cancel_tracker_pkg;

  localparam int FLUSH_EX   = 0;
  localparam int FLUSH_ERTN = 1;
  localparam int FLUSH_BR   = 2;

  function automatic int cnt_w(input int max_out);
    return $clog2(max_out + 1);
  endfunction

endpackage

// File: rtl/if_inflight_cancel_tracker_if.sv
// inst_sram request/response handshake between IF pre-stage and tracker.
// master is the IF/SRAM side, slave is the tracker.
interface if_inflight_cancel_tracker_if;

  logic inst_sram_req;
  logic inst_sram_addr_ok;
  logic inst_sram_data_ok;
  logic req_allow;
  logic data_discard;

  modport master (
    output inst_sram_req,
    output inst_sram_addr_ok,
    output inst_sram_data_ok,
    input  req_allow,
    input  data_discard
  );

  modport slave (
    input  inst_sram_req,
    input  inst_sram_addr_ok,
    input  inst_sram_data_ok,
    output req_allow,
    output data_discard
  );

endinterface

// File: rtl/if_inflight_cancel_tracker_sat_updown_counter.sv
// Saturating up/down counter with load; load has priority.
// Exposes its next value so callers can chain on it.
module sat_updown_counter #(
  parameter int W   = 2,
  parameter int MAX = 3
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         inc,
  input  logic         dec,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] cnt,
  output logic [W-1:0] cnt_next
);

  logic at_max;
  logic at_min;

  assign at_max = (cnt == W'(MAX));
  assign at_min = (cnt == '0);

  // next value: load, else clamped step; inc with dec holds
  always_comb begin
    cnt_next = cnt;
    if (load) begin
      cnt_next = load_val;
    end else if (inc && !dec && !at_max) begin
      cnt_next = cnt + 1'b1;
    end else if (dec && !inc && !at_min) begin
      cnt_next = cnt - 1'b1;
    end
  end

  // count register, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!resetn) cnt <= '0;
    else         cnt <= cnt_next;
  end

endmodule

// File: rtl/if_inflight_cancel_tracker.sv
// Tracks accepted-but-unreturned inst_sram requests and, on flush,
// marks them all stale so their data_ok beats are discarded.
module if_inflight_cancel_tracker
  import if_inflight_cancel_tracker_pkg::*;
#(
  parameter  int MAX_OUTSTANDING = 2,
  parameter  int NUM_FLUSH       = 3,
  localparam int CNT_W           = cnt_w(MAX_OUTSTANDING)
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [NUM_FLUSH-1:0] flush,
  if_inflight_cancel_tracker_if.slave bus,
  output logic                 cancelling,
  output logic [CNT_W-1:0]     outstanding,
  output logic [CNT_W-1:0]     cancel_cnt,
  output logic                 err
);

  logic             acc;
  logic             ret;
  logic             any_flush;
  logic             full;
  logic             empty;
  logic             err_set;
  logic [CNT_W-1:0] out_next;
  logic [CNT_W-1:0] cancel_unused;

  assign acc       = bus.inst_sram_req & bus.inst_sram_addr_ok;
  assign ret       = bus.inst_sram_data_ok;
  assign any_flush = |flush;
  assign full      = (outstanding == CNT_W'(MAX_OUTSTANDING));
  assign empty     = (outstanding == '0);

  sat_updown_counter #(
    .W   (CNT_W),
    .MAX (MAX_OUTSTANDING)
  ) u_out_cnt (
    .clk      (clk),
    .resetn   (resetn),
    .inc      (acc),
    .dec      (ret),
    .load     (1'b0),
    .load_val ('0),
    .cnt      (outstanding),
    .cnt_next (out_next)
  );

  // a flush reloads with the post-cycle in-flight count
  sat_updown_counter #(
    .W   (CNT_W),
    .MAX (MAX_OUTSTANDING)
  ) u_cancel_cnt (
    .clk      (clk),
    .resetn   (resetn),
    .inc      (1'b0),
    .dec      (ret),
    .load     (any_flush),
    .load_val (out_next),
    .cnt      (cancel_cnt),
    .cnt_next (cancel_unused)
  );

  assign cancelling       = (cancel_cnt != '0);
  assign bus.data_discard = ret & cancelling;
  assign bus.req_allow    = (outstanding < CNT_W'(MAX_OUTSTANDING)) | ret;

  assign err_set = (acc & full & ~ret) | (ret & empty);

  // sticky protocol error flag
  always_ff @(posedge clk) begin
    if (!resetn)      err <= 1'b0;
    else if (err_set) err <= 1'b1;
  end

endmodule

// File: doc/if_inflight_cancel_tracker.md
Name: if_inflight_cancel_tracker

Overview:
- Parametrised tracker of outstanding instruction-SRAM requests for the IF stage.
- Counts requests accepted (addr_ok) but not yet returned (data_ok).
- On any flush (exception, ertn, branch), marks every in-flight response as stale and discards exactly that many later data_ok beats.
- Sits between the IF pre-stage request logic and the inst_sram interface; replaces the fixed two-deep cancel FSM with a depth-generic counter pair.

Parameters:
- MAX_OUTSTANDING, 2, maximum accepted-but-unreturned requests (≥1).
- NUM_FLUSH, 3, number of independent flush sources (e.g. wb_ex, ertn, id_br_taken).
- CNT_W, $clog2(MAX_OUTSTANDING+1), width of the count outputs. Derived; do not override.

Ports:
- clk  in  1  clock.
- resetn  in  1  synchronous, active-low reset.
- flush  in  NUM_FLUSH  flush requests, one per source; ORed internally.
- inst_sram_req  in  1  request valid from the IF pre-stage.
- inst_sram_addr_ok  in  1  request accepted by the SRAM bridge.
- inst_sram_data_ok  in  1  response beat returned.
- req_allow  out  1  IF pre-stage may assert inst_sram_req this cycle.
- data_discard  out  1  current data_ok beat is stale; IF must not capture it.
- cancelling  out  1  cancel_cnt != 0.
- outstanding  out  CNT_W  accepted, unreturned requests.
- cancel_cnt  out  CNT_W  stale responses still to discard.
- err  out  1  sticky protocol error flag.

Behaviour:
Definitions:
- acc = inst_sram_req & inst_sram_addr_ok
- ret = inst_sram_data_ok
- any_flush = |flush

Registers: outstanding, cancel_cnt, err. All three are 0 at reset. Reset wins over every other event in the same cycle.

Outstanding count:
- outstanding_next = outstanding + acc - ret.
- acc and ret in the same cycle leave the count unchanged.

Cancel count, no flush:
- If ret and cancel_cnt != 0: cancel_cnt decrements by 1.
- Otherwise: cancel_cnt holds.

Cancel count, any_flush:
- cancel_cnt_next = outstanding_next.
- This covers a request accepted in the flush cycle: it belongs to the old PC, so it is counted as stale.
- A ret in the flush cycle is not counted.
- Flush during an active cancel reloads the count; it does not add to it.
- Simultaneous flush sources act as a single flush.

data_discard:
- Combinational: data_discard = ret & (cancel_cnt != 0).
- Uses the registered cancel_cnt, independent of any same-cycle flush.
- A non-discarded ret in a flush cycle is killed by the IF valid flush, not by this block.

req_allow:
- Combinational: req_allow = (outstanding < MAX_OUTSTANDING) | ret.
- A return frees a slot in the same cycle.

cancelling: combinational, equal to (cancel_cnt != 0).

Invariant: cancel_cnt <= outstanding at all times.

Error detection (err set, sticky until reset):
- acc while outstanding == MAX_OUTSTANDING and no ret in that cycle.
- ret while outstanding == 0.
- On error, both counters saturate: no wrap past MAX_OUTSTANDING, no underflow below 0.

Mode view, for documentation only (no separate state register):
- NORMAL: cancel_cnt == 0.
- CANCELLING: cancel_cnt > 0.
- NORMAL → CANCELLING on any_flush with outstanding_next > 0.
- CANCELLING → NORMAL when the last stale ret is discarded and no flush occurs in that cycle.

Decomposition:
- Shared package:
  - FLUSH_EX, FLUSH_ERTN, FLUSH_BR: bit indices into flush.
  - CNT_W calculation function.
- Sub-module sat_updown_counter (width param; inc, dec, load, load_val; saturating) is instantiated twice: once for outstanding, once for cancel_cnt.
- Top level holds only the flush OR, discard/allow logic, and the err flag.

Test Plan (MAX_OUTSTANDING=2, NUM_FLUSH=3):
- Reset then idle: resetn=0 for 2 cycles → outstanding=0, cancel_cnt=0, req_allow=1, err=0. One acc, then ret 3 cycles later → outstanding goes 1 then 0, data_discard=0 throughout.
- Two accs, then flush[FLUSH_EX]=1 with no acc/ret that cycle → cancel_cnt=2. The next two rets give data_discard=1 on each, then cancel_cnt=0 and cancelling=0. A third acc/ret pair → data_discard=0.
- One outstanding; flush[FLUSH_BR] in the same cycle as acc → cancel_cnt=2, outstanding=2, req_allow=0 until the next ret.
- outstanding=1, cancel_cnt=1. Ret (discarded) and flush[FLUSH_ERTN] in the same cycle → cancel_cnt=0, outstanding=0, data_discard=1 for that beat.
- outstanding=2, cancel_cnt=1. Second flush with acc+ret in the same cycle → cancel_cnt reloads to 2, outstanding stays 2.
- Error cases: ret with outstanding=0 → err=1, outstanding stays 0. Separately, acc at outstanding=2 with no ret → err=1, outstanding stays 2. resetn=0 clears err.
